data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 177 +++++++++++++++++
 tb/tb_data_memory.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//
// Byte-addressable data memory for a single-cycle RV32 datapath. It holds
// DEPTH_WORDS 32-bit words, stored as four byte lanes. Reads are combinational
// and writes happen on the clock edge. The block also tracks faults:
// misaligned accesses and illegal access codes are flagged every cycle.
//
// Ports
//   clk         : clock; all state updates on the rising edge
//   rst         : synchronous, active-high reset (fault registers only)
//   Address     : byte address (ALU result)
//   DataWr      : store data (rs2)
//   DmWr        : store request
//   DmCtrl      : access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   DataRd      : load data, extended to 32 bits (0 while Fault=1)
//   Fault       : combinational fault for the current access
//   FaultSticky : set by the first fault, cleared only by rst
//   FaultAddr   : Address of the first fault
//   FaultCount  : number of faulting cycles, saturating at 255
// -----------------------------------------------------------------------------
module data_memory #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic [31:0] DataWr,
  input  logic        DmWr,
  input  logic [2:0]  DmCtrl,
  output logic [31:0] DataRd,
  output logic        Fault,
  output logic        FaultSticky,
  output logic [31:0] FaultAddr,
  output logic [7:0]  FaultCount
);

  typedef enum logic {CLEAN = 1'b0, FAULTED = 1'b1} fault_state_e;

  // Upper address bits are dropped, so the address space wraps modulo the size.
  logic [AW-1:0] word_idx;
  logic [1:0]    acc_size;
  logic          illegal;
  logic          misaligned;
  logic          store_en;
  logic [3:0]    byte_en;
  logic [31:0]   wr_data;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shifted;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;

  assign word_idx = Address[AW+1:2];
  assign acc_size = DmCtrl[1:0];

  // Code 011 has acc_size 11. Codes 110 and 111 have both top bits set.
  assign illegal = (DmCtrl == 3'b011) || (DmCtrl[2:1] == 2'b11);

  always_comb begin
    misaligned = 1'b0;
    case (acc_size)
      2'b01:   misaligned = Address[0];
      2'b10:   misaligned = |Address[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign Fault = illegal | misaligned;

  // A faulting store, or any store during reset, must not modify memory.
  assign store_en = DmWr & ~Fault & ~rst;

  // Store data is replicated across the lanes.
  // byte_en then selects which lanes take it.
  always_comb begin
    byte_en = 4'b0000;
    wr_data = DataWr;
    case (acc_size)
      2'b00: begin
        byte_en = 4'b0001 << Address[1:0];
        wr_data = {4{DataWr[7:0]}};
      end
      2'b01: begin
        byte_en = Address[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{DataWr[15:0]}};
      end
      2'b10: begin
        byte_en = 4'b1111;
        wr_data = DataWr;
      end
      default: begin
        byte_en = 4'b0000;
        wr_data = DataWr;
      end
    endcase
  end

  // Each lane is its own array.
  // This lets a partial store touch only the selected bytes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (store_en && byte_en[gi]) begin
          lane_mem[word_idx] <= wr_data[8*gi +: 8];
        end
      end

      // In the store cycle, the read returns the old contents.
      assign rd_word[8*gi +: 8] = lane_mem[word_idx];
    end
  endgenerate

  assign rd_shifted = rd_word >> {Address[1:0], 3'b000};
  assign rd_byte    = rd_shifted[7:0];
  assign rd_half    = Address[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    DataRd = 32'h0000_0000;
    if (!Fault) begin
      case (DmCtrl)
        3'b000:  DataRd = {{24{rd_byte[7]}}, rd_byte};
        3'b100:  DataRd = {24'h0, rd_byte};
        3'b001:  DataRd = {{16{rd_half[15]}}, rd_half};
        3'b101:  DataRd = {16'h0, rd_half};
        3'b010:  DataRd = rd_word;
        default: DataRd = 32'h0000_0000;
      endcase
    end
  end

  // Fault tracking
  fault_state_e state_q, state_d;
  logic [31:0]  fault_addr_q, fault_addr_d;
  logic [7:0]   fault_count_q, fault_count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CLEAN;
      fault_addr_q  <= 32'h0;
      fault_count_q <= 8'h0;
    end else begin
      state_q       <= state_d;
      fault_addr_q  <= fault_addr_d;
      fault_count_q <= fault_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    fault_addr_d  = fault_addr_q;
    fault_count_d = fault_count_q;
    case (state_q)
      CLEAN: begin
        if (Fault) begin
          state_d      = FAULTED;
          fault_addr_d = Address;
        end
      end
      FAULTED: begin
        state_d = FAULTED;
      end
      default: state_d = CLEAN;
    endcase
    if (Fault && (fault_count_q != 8'hFF)) begin
      fault_count_d = fault_count_q + 8'd1;
    end
  end

  assign FaultSticky = (state_q == FAULTED);
  assign FaultAddr   = fault_addr_q;
  assign FaultCount  = fault_count_q;

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
//
// Directed self-checking bench for data_memory, with hand-computed expected
// values. Inputs change 1 time unit after a rising edge. Outputs are sampled
// 1 time unit later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_data_memory;

  localparam logic [2:0] C_B  = 3'b000;
  localparam logic [2:0] C_H  = 3'b001;
  localparam logic [2:0] C_W  = 3'b010;
  localparam logic [2:0] C_BU = 3'b100;
  localparam logic [2:0] C_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Address;
  logic [31:0] DataWr;
  logic        DmWr;
  logic [2:0]  DmCtrl;
  logic [31:0] DataRd;
  logic        Fault;
  logic        FaultSticky;
  logic [31:0] FaultAddr;
  logic [7:0]  FaultCount;

  int tests_run    = 0;
  int tests_failed = 0;

  data_memory #(.DEPTH_WORDS(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .Address     (Address),
    .DataWr      (DataWr),
    .DmWr        (DmWr),
    .DmCtrl      (DmCtrl),
    .DataRd      (DataRd),
    .Fault       (Fault),
    .FaultSticky (FaultSticky),
    .FaultAddr   (FaultAddr),
    .FaultCount  (FaultCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Apply inputs, then wait 1 time unit so combinational outputs settle.
  task automatic drive(input logic [31:0] addr, input logic [31:0] data,
                       input logic wr, input logic [2:0] ctrl);
    Address = addr;
    DataWr  = data;
    DmWr    = wr;
    DmCtrl  = ctrl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] ctrl);
    drive(addr, data, 1'b1, ctrl);
    tick();
    DmWr = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [31:0] addr,
                            input logic [2:0] ctrl, input logic [31:0] exp);
    drive(addr, 32'h0, 1'b0, ctrl);
    check(tag, DataRd, exp);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(32'h0, 32'h0, 1'b0, C_W);
    tick();
    tick();
    check("rst_sticky", {31'h0, FaultSticky}, 32'h0);
    check("rst_faddr", FaultAddr, 32'h0);
    check("rst_fcount", {24'h0, FaultCount}, 32'h0);
    rst = 1'b0;

    // A store requested during reset must be suppressed.
    // The read stays combinational throughout.
    store(32'h50, 32'h0000_0000, C_W);
    rst = 1'b1;
    drive(32'h50, 32'hFFFF_FFFF, 1'b1, C_W);
    check("rst_read_comb", DataRd, 32'h0);
    tick();
    rst = 1'b0;
    DmWr = 1'b0;
    load_check("rst_store_blocked", 32'h50, C_W, 32'h0);

    // Byte and halfword loads with sign and zero extension
    store(32'h10, 32'h8180_7F01, C_W);
    load_check("lb_10", 32'h10, C_B, 32'h0000_0001);
    load_check("lb_11", 32'h11, C_B, 32'h0000_007F);
    load_check("lb_12", 32'h12, C_B, 32'hFFFF_FF80);
    load_check("lb_13", 32'h13, C_B, 32'hFFFF_FF81);
    load_check("lbu_13", 32'h13, C_BU, 32'h0000_0081);
    load_check("lh_12", 32'h12, C_H, 32'hFFFF_8180);
    load_check("lhu_12", 32'h12, C_HU, 32'h0000_8180);
    load_check("lh_10", 32'h10, C_H, 32'h0000_7F01);

    // Partial stores touch only their own lanes.
    store(32'h20, 32'h0000_0000, C_W);
    store(32'h22, 32'h0000_00AA, C_B);
    store(32'h20, 32'h0000_1234, C_H);
    load_check("partial_lw", 32'h20, C_W, 32'h00AA_1234);

    // Codes 100 and 101 store as byte and halfword.
    store(32'h60, 32'h0000_0000, C_W);
    store(32'h61, 32'hFFFF_FF5A, C_BU);
    store(32'h66, 32'hFFFF_BEEF, C_HU);
    load_check("sbu_lw", 32'h60, C_W, 32'h0000_5A00);
    load_check("shu_lw", 32'h64, C_W, 32'hBEEF_0000);

    // Address wrap at 4*DEPTH_WORDS bytes
    store(32'h1000, 32'h5555_AAAA, C_W);
    load_check("wrap_lw", 32'h0, C_W, 32'h5555_AAAA);

    // Read during write returns the old data.
    // The new data appears the following cycle.
    store(32'h40, 32'h1111_1111, C_W);
    drive(32'h40, 32'h2222_2222, 1'b1, C_W);
    check("rdw_old", DataRd, 32'h1111_1111);
    tick();
    drive(32'h40, 32'h0, 1'b0, C_W);
    check("rdw_new", DataRd, 32'h2222_2222);
    tick();

    // First fault: a misaligned SW. Memory stays unchanged and the address is captured.
    store(32'h24, 32'h1234_5678, C_W);
    drive(32'h25, 32'hDEAD_BEEF, 1'b1, C_W);
    check("mis_sw_fault", {31'h0, Fault}, 32'h1);
    check("mis_sw_rd0", DataRd, 32'h0);
    check("mis_sw_sticky_pre", {31'h0, FaultSticky}, 32'h0);
    tick();
    drive(32'h24, 32'h0, 1'b0, C_W);
    check("mis_sw_sticky", {31'h0, FaultSticky}, 32'h1);
    check("mis_sw_faddr", FaultAddr, 32'h25);
    check("mis_sw_fcount", {24'h0, FaultCount}, 32'h1);
    check("mis_sw_nofault", {31'h0, Fault}, 32'h0);
    load_check("mis_sw_mem", 32'h24, C_W, 32'h1234_5678);

    // A later fault leaves the captured address unchanged.
    drive(32'h32, 32'h0, 1'b0, C_W);
    check("fault32", {31'h0, Fault}, 32'h1);
    tick();
    drive(32'h0, 32'h0, 1'b0, C_W);
    check("faddr_hold", FaultAddr, 32'h25);
    check("fcount_2", {24'h0, FaultCount}, 32'h2);

    // Fault detection, without and with faulting inputs
    drive(32'h33, 32'h0, 1'b0, C_BU);
    check("lbu_odd_ok", {31'h0, Fault}, 32'h0);
    drive(32'h11, 32'h0, 1'b0, C_HU);
    check("lhu_mis", {31'h0, Fault}, 32'h1);
    drive(32'h12, 32'h0, 1'b0, C_H);
    check("lh_ok", {31'h0, Fault}, 32'h0);
    drive(32'h10, 32'h0, 1'b0, 3'b011);
    check("ill_011", {31'h0, Fault}, 32'h1);
    drive(32'h10, 32'h0, 1'b0, 3'b110);
    check("ill_110", {31'h0, Fault}, 32'h1);
    check("ill_110_rd", DataRd, 32'h0);
    drive(32'h0, 32'h0, 1'b0, C_W);
    tick();
    check("fcount_still2", {24'h0, FaultCount}, 32'h2);

    // Hold an illegal code long enough for the counter to saturate.
    drive(32'h10, 32'h0, 1'b0, 3'b111);
    for (int i = 0; i < 300; i++) begin
      check("sat_rd0", DataRd, 32'h0);
      tick();
    end
    check("sat_255", {24'h0, FaultCount}, 32'hFF);
    tick();
    check("sat_stable", {24'h0, FaultCount}, 32'hFF);
    check("sat_faddr", FaultAddr, 32'h25);

    // Reset takes priority over a fault in the same cycle.
    rst = 1'b1;
    check("rstf_fault", {31'h0, Fault}, 32'h1);
    tick();
    rst = 1'b0;
    drive(32'h0, 32'h0, 1'b0, C_W);
    check("rstf_sticky", {31'h0, FaultSticky}, 32'h0);
    check("rstf_faddr", FaultAddr, 32'h0);
    check("rstf_fcount", {24'h0, FaultCount}, 32'h0);
    load_check("rst_keeps_mem", 32'h40, C_W, 32'h2222_2222);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
